instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Sequential instruction fetcher. Issues word-aligned requests from a fetch PC, tags
// every accepted request with its PC in an in-order queue and stores each response
// together with its PC in an instruction buffer that feeds decode. A Redirect flushes
// the buffer and the tag queue, reloads the PC and discards responses still in flight.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   ImemReqValid/Ready/Addr    fetch request handshake and word address
//   ImemRspValid/Data          in-order read responses, no backpressure
//   Redirect/RedirectAddr      one-cycle flush and restart at a new address
//   InstrValid/Ready           decode handshake
//   Instr/InstrPC              head instruction word and its fetch address
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC
);

    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [31:0]   pc_q;
    logic [CW-1:0] out_q;   // accepted requests not yet answered, including doomed ones
    logic [CW-1:0] drop_q;  // responses still owed to requests issued before a Redirect
    logic [CW-1:0] occ_q;
    logic [PW-1:0] tag_wr_q, tag_rd_q, buf_wr_q, buf_rd_q;

    logic [31:0] tag_mem  [DEPTH];
    logic [31:0] buf_data [DEPTH];
    logic [31:0] buf_pc   [DEPTH];

    logic req_fire;
    logic rsp_ok;
    logic rsp_keep;
    logic deq;
    logic unused_addr_lsb;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign unused_addr_lsb = ^RedirectAddr[1:0];

    always_comb begin
        // Counting outstanding requests against the buffer guarantees a slot per response.
        ImemReqValid = !reset && !Redirect && ((out_q + occ_q) < DEPTH_C);
        InstrValid   = !reset && !Redirect && (occ_q != '0);
        ImemReqAddr  = reset ? RESET_PC : pc_q;
        Instr        = reset ? '0 : buf_data[buf_rd_q];
        InstrPC      = reset ? '0 : buf_pc[buf_rd_q];
        req_fire     = ImemReqValid && ImemReqReady;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_ok       = !reset && ImemRspValid && (out_q != '0);
        rsp_keep     = rsp_ok && !Redirect && (drop_q == '0);
        deq          = InstrValid && InstrReady;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            occ_q    <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            buf_wr_q <= '0;
            buf_rd_q <= '0;
        end else begin
            if (req_fire && !rsp_ok) begin
                out_q <= out_q + CW'(1);
            end else if (!req_fire && rsp_ok) begin
                out_q <= out_q - CW'(1);
            end

            if (Redirect) begin
                pc_q     <= {RedirectAddr[31:2], 2'b00};
                // Everything still in flight after this cycle's response belongs to the old path.
                drop_q   <= out_q - CW'(rsp_ok);
                occ_q    <= '0;
                tag_wr_q <= '0;
                tag_rd_q <= '0;
                buf_wr_q <= '0;
                buf_rd_q <= '0;
            end else begin
                if (rsp_ok && (drop_q != '0)) begin
                    drop_q <= drop_q - CW'(1);
                end
                if (req_fire) begin
                    pc_q     <= pc_q + 32'd4;
                    tag_wr_q <= ptr_inc(tag_wr_q);
                end
                if (rsp_keep) begin
                    tag_rd_q <= ptr_inc(tag_rd_q);
                    buf_wr_q <= ptr_inc(buf_wr_q);
                end
                if (deq) begin
                    buf_rd_q <= ptr_inc(buf_rd_q);
                end
                if (rsp_keep && !deq) begin
                    occ_q <= occ_q + CW'(1);
                end else if (!rsp_keep && deq) begin
                    occ_q <= occ_q - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            buf_data[buf_wr_q] <= ImemRspData;
            buf_pc[buf_wr_q]   <= tag_mem[tag_rd_q];
        end
    end

endmodule
